rand_delay_multi: RTL and testbench
===================================

// Module: rand_delay_multi
// PURPOSE
//  Parametrised N-channel reaction-time engine; successor to the single-player random-delay timer.
//  On start it waits a pseudo-random delay, raises led, then time-stamps each channel's stop press.
//  Adds false-start detection per channel, configurable delay range/step/timeout, and a done pulse.
//  Sits between the debounced button/start logic and the display/score formatter.
// PARAMETERS
//  N_CH        2       number of player channels (>=1)
//  TW          10      timing result width; all-ones (2**TW-1) is the reserved fail code
//  STEP_TICKS  1000    tic cycles per random delay step (>=1)
//  MIN_STEPS   2       minimum delay in steps
//  SPAN_LOG2   4       random span: delay = (MIN_STEPS + lfsr[SPAN_LOG2-1:0]) * STEP_TICKS
//  TIMEOUT     1000    reaction window in tic cycles; must be < 2**TW-1
//  SEED        16'hACE1 LFSR reset value, nonzero
// PORTS
//  tic          in   1        clock
//  rst          in   1        async reset, active-high
//  en           in   1        start round (level, sampled per edge)
//  stp          in   N_CH     per-channel stop/press
//  led          out  1        go light
//  state        out  2        FSM state (rt_pkg encoding)
//  timing       out  N_CH*TW  channel i at [i*TW +: TW]
//  false_start  out  N_CH     channel pressed before led
//  done         out  1        one-cycle pulse on FINISH entry
// BEHAVIOUR
//  - Reset: state=IDLE, led=0, timing=all-ones per channel, false_start=0, done=0, lfsr=SEED, counters 0.
//  - LFSR free-runs one step every tic regardless of state; delay sampled from it when en accepted.
//  - Priority per edge: rst > en > stp > counting. en honoured only in IDLE or FINISH; ignored in WAIT/ARMED.
//  - IDLE/FINISH + en: load delay, cnt=0, clear timing to 0, false_start=0, lock flags=0, led=0 -> WAIT.
//  - WAIT: cnt increments each tic. stp[i] on unlocked ch: timing[i]=all-ones, false_start[i]=1, lock i.
//    All channels locked -> FINISH (led stays 0). cnt==delay-1 at an edge -> ARMED, led=1, cnt=0.
//  - ARMED: cnt increments each tic. stp[i] on unlocked ch: timing[i]=cnt (press at first edge after
//    entry gives 0), lock i. Locked channels ignore further stp. Multiple channels same edge all latch.
//    All locked -> FINISH. cnt==TIMEOUT-1 -> FINISH; unlocked channels get all-ones, false_start stays 0;
//    stp at that same edge is still latched as a valid time.
//  - FINISH: led=0, results held until next accepted en; done=1 only on the entry edge.
//  - Arithmetic: delay counter width $clog2((MIN_STEPS+2**SPAN_LOG2)*STEP_TICKS+1); no wrap possible.
//  - rst mid-round: immediate return to reset values; no done pulse.
// CONFIGURATION
//  REACT_BEST_EN defined: extra outputs best_time [TW] and best_ch [CHW], CHW=max(1,$clog2(N_CH));
//   tracks minimum valid (non-fail) timing since reset; reset best_time=all-ones, best_ch=0;
//   updated on the edge a valid time is latched if strictly smaller; lower channel index wins ties.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  rt_pkg: state_t enum {IDLE=2'b00, WAIT=2'b01, ARMED=2'b10, FINISH=2'b11}; LFSR_W=16;
//   LFSR_TAPS=16'hB400; function fail_code(TW) returning all-ones.
//  Sub-module rt_lfsr (Galois, LFSR_W, taps, seed param; tic/rst/q) instantiated once.
// TESTING  (N_CH=2, TW=10, STEP_TICKS=4, MIN_STEPS=2, SPAN_LOG2=2, TIMEOUT=20)
//  1 rst asserted mid-ARMED -> state=00, led=0, timing=20'hFFFFF, lfsr=SEED next cycle, no done.
//  2 en with lfsr[1:0]=1 -> WAIT, led rises after exactly 12 tic; ch0 stp 5 edges later -> timing[0]=5.
//  3 ch1 stp during WAIT -> false_start=2'b10, timing[1]=10'h3FF; ch0 reacts 3 -> done, timing[0]=3.
//  4 no presses -> FINISH after 20 ARMED edges, both timing=10'h3FF, false_start=0, done 1 cycle.
//  5 both stp same edge cnt=7, then en held in ARMED -> both 7, en ignored; en in FINISH restarts WAIT.
//  6 REACT_BEST_EN: rounds with ch0=9,ch1=6 then ch0=6 -> best_time=6, best_ch=1 (tie kept).

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-time engine: FSM encoding,
// LFSR geometry and the reserved all-ones fail code.
package rt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ARMED  = 2'b10,
    FINISH = 2'b11
  } state_t;

  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // All-ones of the given width, used as the "no valid time" result code.
  function automatic logic [31:0] fail_code(input int tw);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < tw) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rt_lfsr.sv
// Free-running Galois LFSR (right-shifting); exposes its low Q_W bits as the
// random source for the delay draw.
module rt_lfsr
  import rt_pkg::*;
#(
  parameter int           W    = LFSR_W,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter int           Q_W  = W
) (
  input  logic           tic,
  input  logic           rst,
  output logic [Q_W-1:0] q
);

  logic [W-1:0] r_lfsr;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge tic or posedge rst) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= {1'b0, r_lfsr[W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
  end

  assign q = r_lfsr[Q_W-1:0];

endmodule

// File: rtl/rand_delay_multi.sv
// N-channel reaction-time engine: random arming delay, per-channel time stamps,
// false-start detection and a done pulse. Define REACT_BEST_EN for best-time tracking.
module rand_delay_multi
  import rt_pkg::*;
#(
  parameter int                N_CH       = 2,
  parameter int                TW         = 10,
  parameter int                STEP_TICKS = 1000,
  parameter int                MIN_STEPS  = 2,
  parameter int                SPAN_LOG2  = 4,
  parameter int                TIMEOUT    = 1000,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
  input  logic              tic,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   stp,
  output logic              led,
  output logic [1:0]        state,
  output logic [N_CH*TW-1:0] timing,
  output logic [N_CH-1:0]   false_start,
  output logic              done
`ifdef REACT_BEST_EN
  , output logic [TW-1:0]   best_time
  , output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] best_ch
`endif
);

  localparam logic [TW-1:0] FAIL    = TW'(fail_code(TW));
  localparam int            DLY_MAX = (MIN_STEPS + 2**SPAN_LOG2) * STEP_TICKS;
  localparam int            DLY_W   = $clog2(DLY_MAX + 1);
  localparam int            TMO_W   = $clog2(TIMEOUT + 1);
  localparam int            CNT_W   = (DLY_W > TMO_W) ? DLY_W : TMO_W;

  logic [SPAN_LOG2-1:0] w_rand;
  logic [CNT_W-1:0]     w_delay_sample;

  state_t               r_state, w_state_nxt;
  logic                 r_led, w_led_nxt;
  logic [N_CH*TW-1:0]   r_timing, w_timing_nxt;
  logic [N_CH-1:0]      r_fs, w_fs_nxt;
  logic [N_CH-1:0]      r_lock, w_lock_nxt;
  logic                 r_done, w_done_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]     r_delay, w_delay_nxt;

  rt_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED),
    .Q_W  (SPAN_LOG2)
  ) u_lfsr (
    .tic (tic),
    .rst (rst),
    .q   (w_rand)
  );

  assign w_delay_sample = CNT_W'((MIN_STEPS + int'(w_rand)) * STEP_TICKS);

  always_ff @(posedge tic or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_led    <= 1'b0;
      r_timing <= {N_CH{FAIL}};
      r_fs     <= '0;
      r_lock   <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_delay  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_led    <= w_led_nxt;
      r_timing <= w_timing_nxt;
      r_fs     <= w_fs_nxt;
      r_lock   <= w_lock_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
      r_delay  <= w_delay_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the case
    // leaves one unassigned and infers a latch.
    w_state_nxt  = r_state;
    w_led_nxt    = r_led;
    w_timing_nxt = r_timing;
    w_fs_nxt     = r_fs;
    w_lock_nxt   = r_lock;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_delay_nxt  = r_delay;

    case (r_state)
      IDLE, FINISH: begin
        if (en) begin
          w_delay_nxt  = w_delay_sample;
          w_cnt_nxt    = '0;
          w_timing_nxt = '0;
          w_fs_nxt     = '0;
          w_lock_nxt   = '0;
          w_led_nxt    = 1'b0;
          w_state_nxt  = WAIT;
        end
      end

      WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          if (stp[i] && !r_lock[i]) begin
            w_timing_nxt[i*TW +: TW] = FAIL;
            w_fs_nxt[i]              = 1'b1;
            w_lock_nxt[i]            = 1'b1;
          end
        end
        // Everyone jumping the gun ends the round before the light ever comes on.
        if (&w_lock_nxt) begin
          w_state_nxt = FINISH;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == r_delay - CNT_W'(1)) begin
          w_state_nxt = ARMED;
          w_led_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      ARMED: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          if (stp[i] && !r_lock[i]) begin
            w_timing_nxt[i*TW +: TW] = TW'(r_cnt);
            w_lock_nxt[i]            = 1'b1;
          end
        end
        if (&w_lock_nxt) begin
          w_state_nxt = FINISH;
          w_led_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Presses on this final edge were latched above; only silent channels fail.
          for (int i = 0; i < N_CH; i++) begin
            if (!w_lock_nxt[i]) w_timing_nxt[i*TW +: TW] = FAIL;
          end
          w_state_nxt = FINISH;
          w_led_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: ;
    endcase
  end

  assign state       = r_state;
  assign led         = r_led;
  assign timing      = r_timing;
  assign false_start = r_fs;
  assign done        = r_done;

`ifdef REACT_BEST_EN
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] w_hit;
  logic [TW-1:0]   r_best_t, w_best_t_nxt;
  logic [CHW-1:0]  r_best_c, w_best_c_nxt;

  assign w_hit = (r_state == ARMED) ? (stp & ~r_lock) : '0;

  // Ascending scan with strict compare: the lower channel keeps a tie.
  always_comb begin
    w_best_t_nxt = r_best_t;
    w_best_c_nxt = r_best_c;
    for (int i = 0; i < N_CH; i++) begin
      if (w_hit[i] && (TW'(r_cnt) < w_best_t_nxt)) begin
        w_best_t_nxt = TW'(r_cnt);
        w_best_c_nxt = CHW'(i);
      end
    end
  end

  always_ff @(posedge tic or posedge rst) begin
    if (rst) begin
      r_best_t <= FAIL;
      r_best_c <= '0;
    end else begin
      r_best_t <= w_best_t_nxt;
      r_best_c <= w_best_c_nxt;
    end
  end

  assign best_time = r_best_t;
  assign best_ch   = r_best_c;
`endif

endmodule

// File: tb/tb_rand_delay_multi.sv
// Scoreboard bench for rand_delay_multi: each round's outcome is predicted from
// press edges and the drawn delay, then compared when done pulses.
module tb_rand_delay_multi;

  localparam int            N_CH      = 2;
  localparam int            TW        = 10;
  localparam int            STEP      = 4;
  localparam int            MIN_STEPS = 2;
  localparam int            SPAN_LOG2 = 2;
  localparam int            TIMEOUT   = 20;
  localparam logic [15:0]   SEED      = 16'hACE1;
  localparam logic [TW-1:0] FAILC     = 10'h3FF;

  logic              tic;
  logic              rst;
  logic              en;
  logic [N_CH-1:0]   stp;
  logic              led;
  logic [1:0]        state;
  logic [N_CH*TW-1:0] timing;
  logic [N_CH-1:0]   false_start;
  logic              done;
`ifdef REACT_BEST_EN
  logic [TW-1:0]     best_time;
  logic [0:0]        best_ch;
`endif

  rand_delay_multi #(
    .N_CH       (N_CH),
    .TW         (TW),
    .STEP_TICKS (STEP),
    .MIN_STEPS  (MIN_STEPS),
    .SPAN_LOG2  (SPAN_LOG2),
    .TIMEOUT    (TIMEOUT),
    .SEED       (SEED)
  ) dut (
    .tic         (tic),
    .rst         (rst),
    .en          (en),
    .stp         (stp),
    .led         (led),
    .state       (state),
    .timing      (timing),
    .false_start (false_start),
    .done        (done)
`ifdef REACT_BEST_EN
    , .best_time (best_time)
    , .best_ch   (best_ch)
`endif
  );

  initial tic = 1'b0;
  always #5 tic = ~tic;

  typedef struct {
    logic [N_CH*TW-1:0] timing;
    logic [N_CH-1:0]    fs;
    logic [TW-1:0]      best_t;
    logic               best_c;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_checks;
  int            n_errors;
  logic [15:0]   m_lfsr;
  logic [TW-1:0] m_best_t;
  logic          m_best_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: polynomial step x -> x/2 xor taps when the low bit is set.
  always @(posedge tic or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic int cur_delay();
    return (MIN_STEPS + int'(m_lfsr[SPAN_LOG2-1:0])) * STEP;
  endfunction

  always @(negedge tic) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("timing", 32'(timing), 32'(mon_e.timing));
        check("false_start", 32'(false_start), 32'(mon_e.fs));
        check("done_state", 32'(state), 32'd3);
        check("done_led", 32'(led), 32'd0);
`ifdef REACT_BEST_EN
        check("best_time", 32'(best_time), 32'(mon_e.best_t));
        check("best_ch", 32'(best_ch), 32'(mon_e.best_c));
`endif
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_timing"}, 32'(timing), 32'hFFFFF);
    check({tag, "_fs"}, 32'(false_start), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_lfsr"}, 32'(dut.u_lfsr.r_lfsr), 32'(SEED));
`ifdef REACT_BEST_EN
    check({tag, "_best_t"}, 32'(best_time), 32'h3FF);
    check({tag, "_best_c"}, 32'(best_ch), 32'd0);
`endif
    m_best_t = FAILC;
    m_best_c = 1'b0;
  endtask

  // p = edge index (1 = first edge after the en edge) of a channel's press, 0 = none.
  // Called and returns at a falling edge.
  task automatic run_round(input int p0, input int p1, input int h0, input int h1,
                           input bit hold_en);
    int            p[N_CH];
    int            h[N_CH];
    int            d;
    int            end_e;
    int            mx;
    bit            all_locked;
    logic [TW-1:0] t;
    exp_t          e;
    p[0] = p0; p[1] = p1; h[0] = h0; h[1] = h1;
    d          = cur_delay();
    all_locked = 1'b1;
    mx         = 0;
    e.timing   = '0;
    e.fs       = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (p[i] == 0 || p[i] > d + TIMEOUT) begin
        all_locked = 1'b0;
        t = FAILC;
      end else if (p[i] <= d) begin
        t = FAILC;
        e.fs[i] = 1'b1;
      end else begin
        t = TW'(p[i] - d - 1);
        if (t < m_best_t) begin
          m_best_t = t;
          m_best_c = 1'(i);
        end
      end
      e.timing[i*TW +: TW] = t;
      if (p[i] <= d + TIMEOUT && p[i] > mx) mx = p[i];
    end
    end_e    = all_locked ? mx : d + TIMEOUT;
    e.best_t = m_best_t;
    e.best_c = m_best_c;
    sb_q.push_back(e);

    en  = 1'b1;
    stp = '0;
    for (int k = 1; k <= end_e; k++) begin
      @(negedge tic);
      check("round_led", 32'(led), 32'(k - 1 >= d));
      check("round_state", 32'(state), (k - 1 < d) ? 32'd1 : 32'd2);
      en = hold_en;
      for (int i = 0; i < N_CH; i++)
        stp[i] = (p[i] != 0) && (k >= p[i]) && (k < p[i] + h[i]);
    end
    @(negedge tic);
    en  = 1'b0;
    stp = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      stp = N_CH'($urandom);
      @(negedge tic);
    end
    stp = '0;
  endtask

  task automatic abort_round();
    int d;
    d  = cur_delay();
    en = 1'b1;
    repeat (d + 3) begin
      @(negedge tic);
      en = 1'b0;
    end
    check("abort_armed", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge tic);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int pr[N_CH];
    int hd[N_CH];
    n_checks = 0;
    n_errors = 0;
    m_best_t = FAILC;
    m_best_c = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    stp = '0;
    repeat (2) @(negedge tic);
    check_reset("por");
    rst = 1'b0;
    @(negedge tic);

    // Delay of 12 (low LFSR bits = 1); ch0 presses 5 edges after arming.
    for (int i = 0; i < 64 && m_lfsr[1:0] != 2'd1; i++) @(negedge tic);
    d = cur_delay();
    run_round(d + 6, d + 8, 1, 1, 1'b0);

    // ch1 false start, ch0 reacts with 3.
    d = cur_delay();
    run_round(d + 4, 3, 2, 2, 1'b0);

    // Nobody presses: timeout.
    run_round(0, 0, 1, 1, 1'b0);

    // Simultaneous presses with en held through the round, then restart from FINISH.
    d = cur_delay();
    run_round(d + 8, d + 8, 3, 3, 1'b1);
    d = cur_delay();
    run_round(d + 2, d + TIMEOUT, 1, 1, 1'b0);

    // Everyone false-starts, last on the arming edge itself.
    d = cur_delay();
    run_round(2, d, 1, 1, 1'b0);

    abort_round();

    // Best-time sequence from reset: 9/6, then ch0 ties at 6.
    d = cur_delay();
    run_round(d + 10, d + 7, 1, 1, 1'b0);
    d = cur_delay();
    run_round(d + 7, 0, 1, 1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      idle($urandom_range(0, 4));
      d = cur_delay();
      for (int i = 0; i < N_CH; i++) begin
        pr[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, d + TIMEOUT + 3));
        hd[i] = $urandom_range(1, 3);
      end
      run_round(pr[0], pr[1], hd[0], hd[1], $urandom_range(0, 3) == 0);
    end

    idle(3);
    repeat (2) @(negedge tic);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
